// File: rtl/rob_retire_unit.sv
// In-order reorder buffer with retire stage driving the architectural RAT update and free list.
// Optional ROB_EXCEPTION_EN: exceptions block retirement and trigger a one-cycle FLUSH.

module rob_retire_lane #(
  parameter int ARF_WIDTH = 5,
  parameter int PRF_WIDTH = 6
) (
  input  logic                 lane_en,
  input  logic                 e_valid,
  input  logic                 e_done,
  input  logic                 e_blk,
  input  logic [ARF_WIDTH-1:0] e_arn,
  input  logic [PRF_WIDTH-1:0] e_prn,
  input  logic [PRF_WIDTH-1:0] e_old_prn,
  output logic                 retire,
  output logic                 free_valid,
  output logic [ARF_WIDTH-1:0] dest_arn,
  output logic [PRF_WIDTH-1:0] dest_prn,
  output logic [PRF_WIDTH-1:0] free_prn
);
  assign retire     = lane_en & e_valid & e_done & ~e_blk;
  // r0 is hardwired, so its old mapping is never handed back
  assign free_valid = retire & (e_arn != '0);
  assign dest_arn   = retire ? e_arn     : '0;
  assign dest_prn   = retire ? e_prn     : '0;
  assign free_prn   = retire ? e_old_prn : '0;
endmodule

module rob_retire_unit #(
  parameter int MACHINE_WIDTH = 4,
  parameter int ARF_WIDTH     = 5,
  parameter int PRF_WIDTH     = 6,
  parameter int ROB_DEPTH     = 32,
  parameter int ROB_IDX_W     = $clog2(ROB_DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [MACHINE_WIDTH-1:0]           dispatch_valid,
  input  logic [MACHINE_WIDTH*ARF_WIDTH-1:0] dispatch_arn,
  input  logic [MACHINE_WIDTH*PRF_WIDTH-1:0] dispatch_prn,
  input  logic [MACHINE_WIDTH*PRF_WIDTH-1:0] dispatch_old_prn,
  output logic                               dispatch_ready,
  output logic [ROB_IDX_W-1:0]               dispatch_rob_idx,
  input  logic [MACHINE_WIDTH-1:0]           cmpl_valid,
  input  logic [MACHINE_WIDTH*ROB_IDX_W-1:0] cmpl_idx,
  input  logic [MACHINE_WIDTH-1:0]           cmpl_exc,
  output logic [MACHINE_WIDTH-1:0]           retire_valid,
  output logic [MACHINE_WIDTH*ARF_WIDTH-1:0] retire_dest_arn,
  output logic [MACHINE_WIDTH*PRF_WIDTH-1:0] retire_dest_prn,
  output logic [MACHINE_WIDTH-1:0]           free_valid,
  output logic [MACHINE_WIDTH*PRF_WIDTH-1:0] free_prn,
  output logic                               flush_req,
  output logic                               rob_empty
);
  localparam int CNT_W = ROB_IDX_W + 1;

  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_nxt;

  logic [ROB_IDX_W-1:0] head, tail;
  logic [CNT_W-1:0]     count, ret_n, disp_n, acc_n;
  logic [ROB_DEPTH-1:0] e_valid, e_done;
  logic [ARF_WIDTH-1:0] e_arn     [ROB_DEPTH];
  logic [PRF_WIDTH-1:0] e_prn     [ROB_DEPTH];
  logic [PRF_WIDTH-1:0] e_old_prn [ROB_DEPTH];

  logic [MACHINE_WIDTH-1:0][ROB_IDX_W-1:0] hidx, tidx, cidx;
  logic [MACHINE_WIDTH-1:0]                lane_en, blk;

  function automatic logic [CNT_W-1:0] popcnt(input logic [MACHINE_WIDTH-1:0] v);
    popcnt = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) popcnt = popcnt + {{ROB_IDX_W{1'b0}}, v[i]};
  endfunction

  assign ret_n  = popcnt(retire_valid);
  assign disp_n = popcnt(dispatch_valid);
  assign acc_n  = dispatch_ready ? disp_n : '0;

  // Occupancy before this cycle's retire, so a full-width dispatch always fits
  assign dispatch_ready   = (state == RUN) &&
                            ((CNT_W'(ROB_DEPTH) - count) >= CNT_W'(MACHINE_WIDTH));
  assign dispatch_rob_idx = tail;
  assign rob_empty        = (count == '0);
  assign flush_req        = (state == FLUSH);

  for (genvar k = 0; k < MACHINE_WIDTH; k++) begin : g_lane
    assign hidx[k] = head + ROB_IDX_W'(k);
    assign tidx[k] = tail + ROB_IDX_W'(k);
    assign cidx[k] = cmpl_idx[k*ROB_IDX_W +: ROB_IDX_W];
    // Retire is a prefix: each lane is enabled only by the lane below it
    if (k == 0) begin : g_first
      assign lane_en[k] = (state == RUN);
    end else begin : g_rest
      assign lane_en[k] = retire_valid[k-1];
    end
    rob_retire_lane #(.ARF_WIDTH(ARF_WIDTH), .PRF_WIDTH(PRF_WIDTH)) u_lane (
      .lane_en   (lane_en[k]),
      .e_valid   (e_valid[hidx[k]]),
      .e_done    (e_done[hidx[k]]),
      .e_blk     (blk[k]),
      .e_arn     (e_arn[hidx[k]]),
      .e_prn     (e_prn[hidx[k]]),
      .e_old_prn (e_old_prn[hidx[k]]),
      .retire    (retire_valid[k]),
      .free_valid(free_valid[k]),
      .dest_arn  (retire_dest_arn[k*ARF_WIDTH +: ARF_WIDTH]),
      .dest_prn  (retire_dest_prn[k*PRF_WIDTH +: PRF_WIDTH]),
      .free_prn  (free_prn[k*PRF_WIDTH +: PRF_WIDTH])
    );
  end

`ifdef ROB_EXCEPTION_EN
  logic [ROB_DEPTH-1:0] e_exc;
  logic [ROB_IDX_W-1:0] bidx;

  for (genvar k = 0; k < MACHINE_WIDTH; k++) begin : g_blk
    assign blk[k] = e_exc[hidx[k]];
  end

  // The first non-retiring entry becomes head next cycle; flush if it excepted
  assign bidx = head + ret_n[ROB_IDX_W-1:0];

  always_comb begin
    state_nxt = state;
    if (state == FLUSH)
      state_nxt = RUN;
    else if ((ret_n != CNT_W'(MACHINE_WIDTH)) && e_valid[bidx] && e_done[bidx] && e_exc[bidx])
      state_nxt = FLUSH;
  end
`else
  logic unused_exc;
  assign unused_exc = ^cmpl_exc;
  assign blk        = '0;

  always_comb begin
    state_nxt = RUN;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      e_valid <= '0;
      e_done  <= '0;
`ifdef ROB_EXCEPTION_EN
      e_exc   <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == FLUSH) begin
        head    <= '0;
        tail    <= '0;
        count   <= '0;
        e_valid <= '0;
        e_done  <= '0;
`ifdef ROB_EXCEPTION_EN
        e_exc   <= '0;
`endif
      end else begin
        head  <= head + ret_n[ROB_IDX_W-1:0];
        tail  <= tail + acc_n[ROB_IDX_W-1:0];
        count <= count + acc_n - ret_n;
        for (int k = 0; k < MACHINE_WIDTH; k++) begin
          if (cmpl_valid[k] && e_valid[cidx[k]]) begin
            e_done[cidx[k]] <= 1'b1;
`ifdef ROB_EXCEPTION_EN
            e_exc[cidx[k]]  <= cmpl_exc[k];
`endif
          end
        end
        for (int k = 0; k < MACHINE_WIDTH; k++)
          if (retire_valid[k]) e_valid[hidx[k]] <= 1'b0;
        for (int k = 0; k < MACHINE_WIDTH; k++) begin
          if (dispatch_ready && dispatch_valid[k]) begin
            e_valid[tidx[k]] <= 1'b1;
            e_done[tidx[k]]  <= 1'b0;
`ifdef ROB_EXCEPTION_EN
            e_exc[tidx[k]]   <= 1'b0;
`endif
          end
        end
      end
    end
  end

  // Payload is only observed through valid entries, so it needs no reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < MACHINE_WIDTH; k++) begin
      if (dispatch_ready && dispatch_valid[k]) begin
        e_arn[tidx[k]]     <= dispatch_arn[k*ARF_WIDTH +: ARF_WIDTH];
        e_prn[tidx[k]]     <= dispatch_prn[k*PRF_WIDTH +: PRF_WIDTH];
        e_old_prn[tidx[k]] <= dispatch_old_prn[k*PRF_WIDTH +: PRF_WIDTH];
      end
    end
  end
endmodule

// File: doc/rob_retire_unit.md
Name: rob_retire_unit

Overview:
- In-order reorder buffer with a commit stage. It is the producer side of the architectural RAT update interface (retire_valid / retire_dest_arn / retire_dest_prn).
- Accepts up to MACHINE_WIDTH renamed instructions per cycle from dispatch and records out-of-order completions.
- Retires up to MACHINE_WIDTH completed instructions per cycle from the head, in program order. On retire it drives the arch-RAT update and returns each superseded physical register to the free list.

Parameters:
- MACHINE_WIDTH, 4, dispatch/complete/retire lanes per cycle
- ARF_WIDTH, 5, architectural register index width
- PRF_WIDTH, 6, physical register index width
- ROB_DEPTH, 32, entries; power of two, at least 2*MACHINE_WIDTH
- ROB_IDX_W, $clog2(ROB_DEPTH), entry index width

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- dispatch_valid  in  MACHINE_WIDTH  per-lane allocate request; set bits are contiguous from bit 0.
- dispatch_arn  in  MACHINE_WIDTH*ARF_WIDTH  destination arch register per lane; lane k occupies bits [k*ARF_WIDTH +: ARF_WIDTH].
- dispatch_prn  in  MACHINE_WIDTH*PRF_WIDTH  newly allocated physical register per lane.
- dispatch_old_prn  in  MACHINE_WIDTH*PRF_WIDTH  previous mapping of the destination, freed at retire.
- dispatch_ready  out  1  high when at least MACHINE_WIDTH entries are free and state is RUN.
- dispatch_rob_idx  out  ROB_IDX_W  tail index; lane k is allocated (tail+k) mod ROB_DEPTH.
- cmpl_valid  in  MACHINE_WIDTH  per-lane completion strobe.
- cmpl_idx  in  MACHINE_WIDTH*ROB_IDX_W  entry index being completed.
- cmpl_exc  in  MACHINE_WIDTH  completing instruction raised an exception.
- retire_valid  out  MACHINE_WIDTH  lane retires this cycle.
- retire_dest_arn  out  MACHINE_WIDTH*ARF_WIDTH  arch register written by the retiring lane.
- retire_dest_prn  out  MACHINE_WIDTH*PRF_WIDTH  new committed mapping for that register.
- free_valid  out  MACHINE_WIDTH  return the lane's old physical register to the free list.
- free_prn  out  MACHINE_WIDTH*PRF_WIDTH  physical register being freed.
- flush_req  out  1  one-cycle pipeline flush pulse.
- rob_empty  out  1  entry count is zero.

Behaviour:
- Reset values: head=0, tail=0, count=0, all entry valid/done/exc bits cleared, state=RUN.
  - Output values at reset: dispatch_ready=1, rob_empty=1, all other outputs 0.
- Dispatch:
  - Each set lane writes {arn, prn, old_prn} into its entry with valid=1, done=0, exc=0.
  - At the edge, tail and count advance by popcount(dispatch_valid).
  - dispatch_valid while dispatch_ready=0 is ignored; no entry is written.
- Completion:
  - On the edge, sets done (and exc) for cmpl_idx if that entry is valid.
  - Completion to an invalid entry is ignored.
  - A completion written at edge t is eligible to retire in the cycle after t.
- Retire (combinational from registered state):
  - Lane k retires iff entry (head+k) is valid and done, and lanes 0..k-1 all retire.
  - When ROB_EXCEPTION_EN is defined, the entry's exc bit must also be 0.
  - retire_dest_arn / retire_dest_prn come from that entry.
  - free_valid[k] = retire_valid[k] && arn!=0; free_prn = old_prn.
  - At the edge, head advances and count decrements by popcount(retire_valid), and the retired entries' valid bits are cleared.
- Full/empty:
  - dispatch_ready is computed from count before this cycle's retire (conservative).
  - Dispatch and retire in the same cycle are legal: count_next = count + dispatched - retired.
  - Pointers wrap modulo ROB_DEPTH.
- State machine RUN/FLUSH: described under Optional Feature.
- Reset mid-operation: all in-flight entries are discarded immediately (asynchronous reset).

Optional Feature:
- Macro: ROB_EXCEPTION_EN.
- Defined:
  - Exception blocking: retire stops at a done entry with exc=1; lanes below it still retire in that cycle.
  - RUN -> FLUSH when the head entry is valid, done and exc=1.
  - FLUSH lasts exactly one cycle: flush_req=1, retire_valid=0, dispatch_ready=0, and dispatch and completions are ignored.
  - Exit FLUSH -> RUN: head=tail=count=0, all entries cleared. Recovery copies the architectural RAT; the excepting entry is not retired.
- Not defined:
  - cmpl_exc is ignored, exc bits are never set, flush_req is tied 0, and the state stays RUN.

Test Plan:
- Reset, then dispatch 4 lanes (arn 1,2,3,4; prn 10..13; old 1..4) -> dispatch_rob_idx=0 before the edge, 4 after; count=4; retire_valid=0.
- Complete indices 3,1,0 -> next cycle retire_valid=4'b0011 (arn1/prn10, arn2/prn11); free_prn 1,2; then complete idx2 -> retire_valid=4'b0011 for idx2,3.
- Dispatch arn 0 with prn 0, then complete it -> retire_valid=1, free_valid=0.
- Fill to 29 entries -> dispatch_ready=0; retire 1 and dispatch 4 in the same cycle -> dispatch ignored. Run 40 dispatch/retire cycles -> head/tail wrap past 31 with correct order.
- ROB_EXCEPTION_EN: entries 0..2 done, idx1 exc -> cycle 1: retire_valid=4'b0001; cycle 2: flush_req=1; cycle 3: rob_empty=1, dispatch_rob_idx=0.
- Assert rst while 6 entries are in flight -> all outputs drop to reset values asynchronously; after release, rob_empty=1.
